serial_adder_fsm: RTL and testbench



---
 rtl/serial_adder_fsm.sv | 92 +++++++++
 tb/tb_serial_adder_fsm.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_fsm.sv
// Bit-serial LSB-first adder: {cout,sum} = a + b + cin over WIDTH cycles using one
// full-adder cell, a registered carry and a start/busy/done handshake.
module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sha;
    logic [WIDTH-1:0] shb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             bit_s;
    logic             carry_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             last_bit;

    always_comb begin
        bit_s     = sha[0] ^ shb[0] ^ carry;
        carry_nxt = (sha[0] & shb[0]) | (carry & (sha[0] ^ shb[0]));
        res_nxt   = {bit_s, res[WIDTH-1:1]};
        last_bit  = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sha   <= '0;
            shb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sha   <= a;
                        shb   <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    res   <= res_nxt;
                    sha   <= sha >> 1;
                    shb   <= shb >> 1;
                    carry <= carry_nxt;
                    cnt   <= cnt + CW'(1);
                    // The final bit is folded into sum on the same edge that enters DONE.
                    if (last_bit) begin
                        sum   <= res_nxt;
                        cout  <= carry_nxt;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Scoreboard bench for serial_adder_fsm: stimulus pushes expected {cout,sum},
// a forked monitor pops and compares on each done pulse.
module tb_serial_adder_fsm;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned done_cnt = 0;
    logic [W:0]  sbq[$];
    logic [W:0]  last_exp = '0;

    serial_adder_fsm #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic monitor();
        logic       prev_done;
        logic [W:0] exp;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_exp  = '0;
                prev_done = 1'b0;
            end else if (done) begin
                done_cnt++;
                if (prev_done) chk("done_single_cycle", 32'(prev_done), 32'd0);
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'({cout, sum}), 32'h1ff);
                end else begin
                    exp = sbq.pop_front();
                    chk("result", 32'({cout, sum}), 32'(exp));
                    last_exp = exp;
                end
                prev_done = 1'b1;
            end else begin
                chk("output_hold", 32'({cout, sum}), 32'(last_exp));
                prev_done = 1'b0;
            end
        end
    endtask

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                            input logic push, input logic [W:0] exp);
        @(negedge clk);
        a     = ta;
        b     = tb;
        cin   = tc;
        start = 1'b1;
        if (push) sbq.push_back(exp);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic [W:0] exp, input string nm);
        int k;
        start_op(ta, tb, tc, 1'b1, exp);
        k = 1;
        while (k <= 20) begin
            @(negedge clk);
            chk({nm, "_busy"}, 32'(busy), 32'd1);
            if (done) break;
            k++;
        end
        chk({nm, "_latency"}, 32'(k), 32'(W + 1));
        @(negedge clk);
        chk({nm, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int unsigned dc0;
        int          n;
        int          tdone[3];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] diff;
        logic [W:0]   full;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum",  32'(sum),  32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        rst = 1'b0;

        run_op(8'h3C, 8'hA5, 1'b0, 9'h0E1, "basic");
        run_op(8'hFF, 8'h01, 1'b0, 9'h100, "wrap1");
        run_op(8'hFF, 8'h00, 1'b1, 9'h100, "wrap_cin");
        run_op(8'h5A, 8'h33, 1'b0, 9'h08D, "sub_inverse");

        for (int i = 0; i < 256; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            diff = ra - rb;
            full = {1'b0, diff} + {1'b0, rb};
            run_op(diff, rb, 1'b0, {full[W], ra}, "sweep");
        end

        // start and operand changes while busy must not disturb 0x10+0x20
        dc0 = done_cnt;
        start_op(8'h10, 8'h20, 1'b0, 1'b1, 9'h030);
        repeat (2) @(posedge clk);
        #1 start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0; a = 8'h55; b = 8'hAA;
        repeat (15) @(negedge clk);
        chk("ignored_start_pulses", done_cnt - dc0, 32'd1);
        chk("ignored_start_drained", 32'(sbq.size()), 32'd0);

        // reset mid-operation aborts without a done pulse
        dc0 = done_cnt;
        start_op(8'h7F, 8'h01, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_sum",  32'(sum),  32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("midrst_no_done", done_cnt - dc0, 32'd0);
        run_op(8'h7F, 8'h01, 1'b0, 9'h080, "after_rst");

        // start held high: one acceptance every W+2 cycles
        dc0 = done_cnt;
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0;
        sbq.push_back(9'h046);
        sbq.push_back(9'h12C);
        sbq.push_back(9'h100);
        start = 1'b1;
        n = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) begin
                tdone[n] = c;
                n++;
                if (n == 1) begin a = 8'hC8; b = 8'h64; end
                if (n == 2) begin a = 8'h80; b = 8'h80; end
                if (n == 3) begin start = 1'b0; break; end
            end
        end
        start = 1'b0;
        chk("b2b_count", 32'(n), 32'd3);
        if (n == 3) begin
            chk("b2b_gap1", 32'(tdone[1] - tdone[0]), 32'(W + 2));
            chk("b2b_gap2", 32'(tdone[2] - tdone[1]), 32'(W + 2));
        end
        repeat (15) @(negedge clk);
        chk("b2b_pulses", done_cnt - dc0, 32'd3);
        chk("final_drained", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
